// File: rtl/dcache_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller_if
// Description : CPU-side and memory-side bus bundle for the L1 data cache
//               controller.
//               CPU side : cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
//                          cpu_data_o, cpu_stall_o
//               Mem side : mem_req_o, mem_write_o, mem_addr_o, mem_data_o,
//                          mem_data_i, mem_ack_i
//               The slave modport is the cache controller; the master modport
//               is the environment (pipeline plus memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_controller_if #(
  parameter int LINE_BITS = 256
);
  logic                 cpu_req_i;
  logic                 cpu_write_i;
  logic [31:0]          cpu_addr_i;
  logic [31:0]          cpu_data_i;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_req_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-back, write-allocate L1 data cache
//               controller. Hits complete combinationally in the same cycle;
//               a miss stalls the pipeline while the FSM writes back a dirty
//               victim line and refills the set over a req/ack memory bus.
// Ports       : clk_i  - clock
//               rst_i  - asynchronous active-high reset
//               bus    - dcache_controller_if.slave (CPU and memory buses)
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller #(
  parameter int SET_BITS  = 4,
  parameter int LINE_BITS = 256,
  parameter int TAG_BITS  = 32 - SET_BITS - 5
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  dcache_controller_if.slave  bus
);

  localparam int c_NUM_SETS = 2 ** SET_BITS;

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_MISS      = 2'd1;
  localparam logic [1:0] c_WRITEBACK = 2'd2;
  localparam logic [1:0] c_ALLOCATE  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [c_NUM_SETS-1:0] r_valid;
  logic [c_NUM_SETS-1:0] r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [c_NUM_SETS];
  logic [LINE_BITS-1:0]  r_line [c_NUM_SETS];

  logic [SET_BITS-1:0]   w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [7:0]            w_bit_ofs;
  logic                  w_idle;
  logic                  w_hit;
  logic                  w_write_hit;
  logic                  w_fill;
  logic                  w_unused_addr;

  assign w_index       = bus.cpu_addr_i[4+SET_BITS:5];
  assign w_tag         = bus.cpu_addr_i[31:5+SET_BITS];
  assign w_bit_ofs     = {bus.cpu_addr_i[4:2], 5'b0};
  assign w_unused_addr = ^bus.cpu_addr_i[1:0];

  assign w_idle      = (r_state == c_IDLE);
  assign w_hit       = bus.cpu_req_i & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_write_hit = w_idle & w_hit & bus.cpu_write_i;
  assign w_fill      = (r_state == c_ALLOCATE) & bus.mem_ack_i;

  // Next-state logic; mem_ack_i only matters in the two bus states.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:      if (bus.cpu_req_i && !w_hit) w_state_nxt = c_MISS;
      c_MISS:      w_state_nxt = (r_valid[w_index] && r_dirty[w_index]) ? c_WRITEBACK : c_ALLOCATE;
      c_WRITEBACK: if (bus.mem_ack_i) w_state_nxt = c_ALLOCATE;
      c_ALLOCATE:  if (bus.mem_ack_i) w_state_nxt = c_IDLE;
      default:     w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Valid/dirty are the only bookkeeping that must be cleared by reset; an
  // aborted refill never reaches w_fill because reset forces IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_write_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Tag and line storage carry no reset; validity gates their use.
  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_line[w_index] <= bus.mem_data_i;
      r_tag[w_index]  <= w_tag;
    end else if (w_write_hit) begin
      r_line[w_index][w_bit_ofs +: 32] <= bus.cpu_data_i;
    end
  end

  // Memory bus outputs are Moore-decoded and forced to zero when idle.
  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_write_o = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_data_o  = '0;
    case (r_state)
      c_WRITEBACK: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_write_o = 1'b1;
        bus.mem_addr_o  = {r_tag[w_index], w_index, 5'b0};
        bus.mem_data_o  = r_line[w_index];
      end
      c_ALLOCATE: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_addr_o  = {w_tag, w_index, 5'b0};
      end
      default: ;
    endcase
  end

  // Stall is raised in the miss-detect cycle itself; reset masks it so all
  // outputs read zero while rst_i is asserted, even with a request pending.
  assign bus.cpu_stall_o = ~rst_i & (~w_idle | (bus.cpu_req_i & ~w_hit));
  assign bus.cpu_data_o  = (w_idle && w_hit && !bus.cpu_write_i) ?
                           r_line[w_index][w_bit_ofs +: 32] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Directed self-checking bench for dcache_controller. A small
//               line-addressed memory answers the cache bus with a chosen
//               ack delay; expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

  logic clk;
  logic rst;

  dcache_controller_if #(.LINE_BITS(256)) bus ();

  dcache_controller #(
    .SET_BITS  (4),
    .LINE_BITS (256)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [255:0] mem [logic [31:0]];

  int          r_stalls;
  int          r_n_wb;
  int          r_n_fetch;
  int          r_req_cycles;
  logic [31:0] r_rdata;
  logic [31:0] r_wb_addr;
  logic [255:0] r_wb_data;
  logic [31:0] r_fetch_addr;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One CPU access held until stall drops; the memory acks on the dly-th
  // cycle of each request phase.
  task automatic access(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int dly);
    int phase;
    bit done;
    phase = 0;
    done  = 1'b0;
    r_stalls = 0; r_n_wb = 0; r_n_fetch = 0; r_req_cycles = 0;
    r_rdata = '0; r_wb_addr = '0; r_wb_data = '0; r_fetch_addr = '0;
    @(negedge clk);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i  = addr;
    bus.cpu_data_i  = wdata;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (!bus.cpu_stall_o) begin
        r_rdata = bus.cpu_data_o;
        done = 1'b1;
      end else begin
        r_stalls++;
        if (bus.mem_req_o) begin
          r_req_cycles++;
          phase++;
          if (phase == dly) begin
            phase = 0;
            if (bus.mem_write_o) begin
              r_wb_addr = bus.mem_addr_o;
              r_wb_data = bus.mem_data_o;
              mem[bus.mem_addr_o] = bus.mem_data_o;
              r_n_wb++;
            end else begin
              r_fetch_addr = bus.mem_addr_o;
              bus.mem_data_i = mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o] : '0;
              r_n_fetch++;
            end
            bus.mem_ack_i = 1'b1;
          end
        end else begin
          check("idle_addr", {224'h0, bus.mem_addr_o}, 256'h0);
          check("idle_data", bus.mem_data_o, 256'h0);
        end
      end
      @(posedge clk);
      #1;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      if (!done) @(negedge clk);
    end
    check("timeout", {255'h0, done}, 256'h1);
    @(negedge clk);
    bus.cpu_req_i   = 1'b0;
    bus.cpu_write_i = 1'b0;
  endtask

  initial begin
    bit got_alloc;
    rst = 1'b1;
    bus.cpu_req_i = 1'b0; bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i = '0;  bus.cpu_data_i = '0;
    bus.mem_data_i = '0;  bus.mem_ack_i = 1'b0;
    mem[32'h400] = {192'h0, 32'hDEAD_BEEF, 32'h0};
    mem[32'h600] = {192'h0, 32'hCAFE_0001, 32'h0};
    mem[32'h800] = {128'h0, 32'h0000_0303, 96'h0};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {255'h0, bus.cpu_stall_o}, 256'h0);
    check("rst_req",   {255'h0, bus.mem_req_o},   256'h0);
    check("rst_data",  {224'h0, bus.cpu_data_o},  256'h0);
    @(negedge clk);
    rst = 1'b0;

    // Cold read miss, ack on 3rd ALLOCATE cycle.
    access(1'b0, 32'h404, 32'h0, 3);
    check("cold_stall", r_stalls, 5);
    check("cold_fetch", {224'h0, r_fetch_addr}, 256'h400);
    check("cold_nwb",   r_n_wb, 0);
    check("cold_rdata", {224'h0, r_rdata}, 256'hDEAD_BEEF);

    // Store hit then load hit.
    access(1'b1, 32'h404, 32'h1234_5678, 1);
    check("wh_stall", r_stalls, 0);
    check("wh_req",   r_req_cycles, 0);
    access(1'b0, 32'h404, 32'h0, 1);
    check("rh_stall", r_stalls, 0);
    check("rh_rdata", {224'h0, r_rdata}, 256'h1234_5678);

    // Conflict miss on dirty line: write-back then refill.
    access(1'b0, 32'h604, 32'h0, 2);
    check("dm_stall", r_stalls, 6);
    check("dm_nwb",   r_n_wb, 1);
    check("dm_wbaddr", {224'h0, r_wb_addr}, 256'h400);
    check("dm_wbword1", {224'h0, r_wb_data[63:32]}, 256'h1234_5678);
    check("dm_fetch", {224'h0, r_fetch_addr}, 256'h600);
    check("dm_rdata", {224'h0, r_rdata}, 256'hCAFE_0001);
    // Refilled line is clean: evicting it needs no write-back.
    access(1'b0, 32'h204, 32'h0, 1);
    check("clean_ev_stall", r_stalls, 3);
    check("clean_ev_nwb",   r_n_wb, 0);
    check("clean_ev_rdata", {224'h0, r_rdata}, 256'h0);

    // Write miss on clean line: allocate, merge store, line goes dirty.
    access(1'b1, 32'h808, 32'hA5A5_0808, 1);
    check("wm_stall", r_stalls, 3);
    check("wm_nwb",   r_n_wb, 0);
    check("wm_fetch", {224'h0, r_fetch_addr}, 256'h800);
    access(1'b0, 32'h808, 32'h0, 1);
    check("wm_word2", {224'h0, r_rdata}, 256'hA5A5_0808);
    access(1'b0, 32'h80C, 32'h0, 1);
    check("wm_word3", {224'h0, r_rdata}, 256'h0000_0303);
    access(1'b0, 32'h004, 32'h0, 1);
    check("wm_ev_stall", r_stalls, 4);
    check("wm_ev_wbaddr", {224'h0, r_wb_addr}, 256'h800);
    check("wm_ev_word2", {224'h0, r_wb_data[95:64]}, 256'hA5A5_0808);

    // Reset asserted during ALLOCATE.
    got_alloc = 1'b0;
    @(negedge clk);
    bus.cpu_req_i = 1'b1; bus.cpu_write_i = 1'b0; bus.cpu_addr_i = 32'h044;
    for (int c = 0; c < 10 && !got_alloc; c++) begin
      #1;
      if (bus.mem_req_o && !bus.mem_write_o) got_alloc = 1'b1;
      else @(negedge clk);
    end
    check("rst_reach_alloc", {255'h0, got_alloc}, 256'h1);
    check("rst_alloc_addr", {224'h0, bus.mem_addr_o}, 256'h040);
    rst = 1'b1;
    #1;
    check("rst_mid_req",   {255'h0, bus.mem_req_o},   256'h0);
    check("rst_mid_stall", {255'h0, bus.cpu_stall_o}, 256'h0);
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 32'h004, 32'h0, 1);
    check("post_rst_004_stall", r_stalls, 3);
    access(1'b0, 32'h404, 32'h0, 1);
    check("post_rst_404_stall", r_stalls, 3);
    check("post_rst_404_fetch", {224'h0, r_fetch_addr}, 256'h400);
    check("post_rst_404_rdata", {224'h0, r_rdata}, 256'h1234_5678);

    // Spurious ack in IDLE with no request.
    @(negedge clk);
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = '1;
    #1;
    check("sp_stall", {255'h0, bus.cpu_stall_o}, 256'h0);
    check("sp_data",  {224'h0, bus.cpu_data_o},  256'h0);
    @(posedge clk);
    #1;
    bus.mem_ack_i = 1'b0;
    bus.mem_data_i = '0;
    check("sp_req", {255'h0, bus.mem_req_o}, 256'h0);
    access(1'b0, 32'h404, 32'h0, 1);
    check("sp_hit_stall", r_stalls, 0);
    check("sp_hit_rdata", {224'h0, r_rdata}, 256'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate L1 data cache controller between the pipeline's MEM stage and off-chip data memory. Tag, valid, dirty and line storage are kept internally. Hits are served in the same cycle. Misses raise a stall to freeze the pipeline while a 4-state FSM writes back a dirty victim and refills the line over a req/ack memory bus.

Parameters:
SET_BITS, 4, index width; number of sets = 2**SET_BITS (16).
LINE_BITS, 256, line width in bits (8 words of 32 bits; offset = addr[4:0]).
TAG_BITS, 32-SET_BITS-5 (23), tag width.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
cpu_req_i  in  1  MEM-stage access valid (MemRead|MemWrite)
cpu_write_i  in  1  1=store, 0=load
cpu_addr_i  in  32  byte address; word aligned, [1:0] ignored
cpu_data_i  in  32  store data
cpu_data_o  out  32  load data
cpu_stall_o  out  1  freeze pipeline
mem_req_o  out  1  memory request, held until ack
mem_write_o  out  1  1=line write-back, 0=line fetch
mem_addr_o  out  32  line address, [4:0]=0
mem_data_o  out  LINE_BITS  write-back line
mem_data_i  in  LINE_BITS  refill line, valid with ack
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Decode: index = addr[4+SET_BITS:5], tag = addr[31:5+SET_BITS], word = addr[4:2].
- hit = cpu_req_i & valid[index] & (tag_store[index] == tag). Combinational.
- Reset: all valid/dirty bits cleared, state IDLE, all outputs 0. Line/tag contents are not reset.
- Reset mid-miss aborts the transfer immediately. mem_req_o drops asynchronously. The refill is discarded.
- States: IDLE, MISS, WRITEBACK, ALLOCATE. Outputs are Moore-decoded from state, except cpu_stall_o and cpu_data_o.
- IDLE:
  - cpu_req_i=0: stall 0, no update.
  - Read hit: cpu_data_o = line word (combinational), stall 0.
  - Write hit: stall 0. On the clock edge, write the word, set dirty.
  - Miss: stall 1 combinationally, go to MISS.
- MISS (1 cycle, stall 1):
  - valid & dirty victim: go to WRITEBACK.
  - Otherwise: go to ALLOCATE.
- WRITEBACK (stall 1): mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line. On mem_ack_i, go to ALLOCATE.
- ALLOCATE (stall 1): mem_req_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}. On mem_ack_i: store mem_data_i, store tag, set valid=1, clear dirty, go to IDLE.
- Return to IDLE: the access now hits and completes normally that cycle. A store is merged and sets dirty (write-allocate).
- Latency:
  - Hit: 0 extra cycles.
  - Clean miss with ack on the Nth ALLOCATE cycle: stall high for 2+N cycles.
  - Dirty miss: add the WRITEBACK cycles.
- mem_ack_i is ignored in IDLE/MISS.
- mem_data_o and mem_addr_o are 0 whenever mem_req_o=0.
- cpu_data_o = 0 unless a read hit occurs in IDLE.
- The CPU holds cpu_req_i, cpu_write_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o=1. Behaviour on violation is unspecified.
- Different tags on the same index evict each other (direct-mapped). No other replacement.

Test Plan:
- Cold read miss at 0x0000_0404, memory acks on 3rd ALLOCATE cycle with line word1=0xDEAD_BEEF -> stall 5 cycles; mem_addr_o=0x0000_0400, mem_write_o=0; next cycle cpu_data_o=0xDEAD_BEEF, stall 0.
- Store 0x1234_5678 to 0x404 (hit), then load 0x404 -> both stall 0; load returns 0x1234_5678; no mem_req_o.
- Load 0x0000_0604 (same index 0, new tag) after dirty store -> WRITEBACK first: mem_write_o=1, mem_addr_o=0x400, mem_data_o word1=0x1234_5678; then ALLOCATE at 0x600; dirty=0 after.
- Write miss to clean line at 0x808 -> ALLOCATE only (no write-back); after fill, word2 = store data, dirty=1; later eviction writes back 0x800.
- Assert rst_i during ALLOCATE -> mem_req_o and cpu_stall_o 0 immediately; state IDLE; re-access 0x404 misses again (valid cleared).
- cpu_req_i=0 with spurious mem_ack_i in IDLE -> no state change, stall 0, cpu_data_o=0.
